mem_sync_rw: RTL and testbench

- Parametrised, clocked successor to the team's edge-triggered byte memory.
- Single-port synchronous RAM with a valid/ready request channel, per-byte write enables and a fixed-latency read response pipeline.
- Sequences a post-reset clear sweep before it accepts traffic.
- Sits between testbench/bus-master stimulus and storage; serves as the reference DUT for TB-to-design timing and race-free sampling exercises.

---
 rtl/mem_sync_rw.sv | 174 +++++++++++++++++
 tb/tb_mem_sync_rw.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sync_rw.sv
// ---------------------------------------------------------------------------
// mem_sync_rw
//   Single-port synchronous RAM with a valid/ready request channel. It has
//   per-byte write enables and a fixed-latency read response pipeline.
//   After reset an optional sweep writes zero to every word, one word per
//   cycle. No requests are accepted until the sweep has finished.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   req_valid      request present
//   req_ready      block accepts a request this cycle
//   req_write      1 = write, 0 = read
//   req_addr       word address
//   req_wdata      write data
//   req_be         byte enables for writes (ignored on reads)
//   rsp_valid      one-cycle pulse per read, RD_LAT cycles after accept
//   rsp_rdata      read data, 0 when rsp_valid = 0
//   rsp_err        address >= DEPTH on that read, qualified by rsp_valid
//   busy           init sweep in progress
//
// Optional feature (macro MEM_SYNC_RW_PARITY_EN)
//   Stores one even-parity bit per byte. Adds two ports:
//   inj_perr       on an accepted write, store inverted parity for every
//                  enabled byte
//   rsp_perr       parity mismatch on any byte of the read word, qualified
//                  by rsp_valid
// ---------------------------------------------------------------------------
module mem_sync_rw #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int DEPTH      = 256,
  parameter int RD_LAT     = 1,
  parameter int INIT_CLEAR = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
`ifdef MEM_SYNC_RW_PARITY_EN
  input  logic                  inj_perr,
  output logic                  rsp_perr,
`endif
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {S_INIT, S_READY} state_t;
  localparam state_t RST_STATE = (INIT_CLEAR != 0) ? S_INIT : S_READY;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   clr_cnt;
  logic               accept, rd_acc, in_range;
  logic [IDX_W-1:0]   idx;
  logic [DATA_W-1:0]  rd_word;

  logic [DATA_W-1:0]  mem [DEPTH];

  // Read pipeline: stage 0 loads at the accept edge, the last stage drives the outputs.
  logic [RD_LAT-1:0]  pv, pe;
  logic [DATA_W-1:0]  pd [RD_LAT];

  assign accept   = req_valid & req_ready;
  assign rd_acc   = accept & ~req_write;
  // The extra top bit lets DEPTH == 2**ADDR_W compare without overflow.
  assign in_range = {1'b0, req_addr} < (ADDR_W + 1)'(DEPTH);
  assign idx      = req_addr[IDX_W-1:0];

  // ---------------------------------------------------------------- FSM
  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  if (clr_cnt == LAST_IDX) state_nxt = S_READY;
      S_READY: state_nxt = S_READY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RST_STATE;
      clr_cnt   <= '0;
      req_ready <= 1'b0;
      busy      <= (INIT_CLEAR != 0);
    end else begin
      state     <= state_nxt;
      // req_ready and busy are flops loaded from the next state, so both outputs are registered.
      req_ready <= (state_nxt == S_READY);
      busy      <= (state_nxt == S_INIT);
      if (state == S_INIT) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------- storage
  // NOTE: the array has no reset; the INIT sweep clears it, and a reset term would block RAM inference.
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      mem[clr_cnt] <= '0;
    end else if (accept && req_write && in_range) begin
      for (int i = 0; i < BE_W; i++)
        if (req_be[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
    end
  end

  assign rd_word = in_range ? mem[idx] : '0;

`ifdef MEM_SYNC_RW_PARITY_EN
  logic [BE_W-1:0]   par_mem [DEPTH];
  logic [RD_LAT-1:0] pp;
  logic              rd_perr;

  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      par_mem[clr_cnt] <= '0;
    end else if (accept && req_write && in_range) begin
      for (int i = 0; i < BE_W; i++)
        if (req_be[i]) par_mem[idx][i] <= (^req_wdata[8*i +: 8]) ^ inj_perr;
    end
  end

  // A byte is in error when its data bits and its stored parity bit have odd parity.
  always_comb begin
    rd_perr = 1'b0;
    if (in_range)
      for (int i = 0; i < BE_W; i++)
        rd_perr = rd_perr | ((^rd_word[8*i +: 8]) ^ par_mem[idx][i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pp <= '0;
    end else begin
      pp[0] <= rd_acc & rd_perr;
      for (int i = 1; i < RD_LAT; i++) pp[i] <= pp[i-1];
    end
  end

  assign rsp_perr = pp[RD_LAT-1];
`endif

  // ---------------------------------------------------------------- read pipeline
  // Data stages hold zero when their valid bit is clear, so rsp_rdata is 0 between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      pe <= '0;
      for (int i = 0; i < RD_LAT; i++) pd[i] <= '0;
    end else begin
      pv[0] <= rd_acc;
      pe[0] <= rd_acc & ~in_range;
      pd[0] <= rd_acc ? rd_word : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  assign rsp_valid = pv[RD_LAT-1];
  assign rsp_err   = pe[RD_LAT-1];
  assign rsp_rdata = pd[RD_LAT-1];

endmodule

// File: tb/tb_mem_sync_rw.sv
// ---------------------------------------------------------------------------
// tb_mem_sync_rw
//   u0: default configuration (8-bit, DEPTH 256, RD_LAT 1).
//   u1: 32-bit, DEPTH 200, RD_LAT 4.
//   Stimulus tasks drive requests on the falling edge and update a reference
//   memory model. Each read pushes its expected response and due cycle onto a
//   per-instance queue. Monitors pop and compare on the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_sync_rw;

  localparam int L0 = 1;
  localparam int L1 = 4;
  localparam int D1 = 200;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        perr;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // u0 signals
  logic        v0 = 0, w0 = 0, inj0 = 0;
  logic [7:0]  a0 = 0, d0 = 0;
  logic [0:0]  be0 = 0;
  logic        rdy0, rv0, re0, busy0, rp0;
  logic [7:0]  rdat0;

  // u1 signals
  logic        v1 = 0, w1 = 0, inj1 = 0;
  logic [7:0]  a1 = 0;
  logic [31:0] d1 = 0;
  logic [3:0]  be1 = 0;
  logic        rdy1, rv1, re1, busy1, rp1;
  logic [31:0] rdat1;

  // reference models
  logic [7:0]  m0   [256];
  logic        bad0 [256];
  logic [31:0] m1   [D1];

  mem_sync_rw u0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(v0), .req_ready(rdy0), .req_write(w0), .req_addr(a0),
    .req_wdata(d0), .req_be(be0),
`ifdef MEM_SYNC_RW_PARITY_EN
    .inj_perr(inj0), .rsp_perr(rp0),
`endif
    .rsp_valid(rv0), .rsp_rdata(rdat0), .rsp_err(re0), .busy(busy0)
  );

  mem_sync_rw #(.DATA_W(32), .ADDR_W(8), .DEPTH(D1), .RD_LAT(L1), .INIT_CLEAR(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(v1), .req_ready(rdy1), .req_write(w1), .req_addr(a1),
    .req_wdata(d1), .req_be(be1),
`ifdef MEM_SYNC_RW_PARITY_EN
    .inj_perr(inj1), .rsp_perr(rp1),
`endif
    .rsp_valid(rv1), .rsp_rdata(rdat1), .rsp_err(re1), .busy(busy1)
  );

`ifndef MEM_SYNC_RW_PARITY_EN
  assign rp0 = 1'b0;
  assign rp1 = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- monitors
  always @(negedge clk) begin
    if (rst_n) begin
      if (rv0) begin
        if (q0.size() == 0) check("u0 unexpected rsp_valid", 1'b1, 1'b0);
        else begin
          exp_t e;
          e = q0.pop_front();
          check("u0 rdata", rdat0, e.data);
          check("u0 err", re0, e.err);
          check("u0 latency", cyc, e.due);
          check("u0 perr", rp0, e.perr);
        end
      end else begin
        check("u0 idle rdata", rdat0, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (rv1) begin
        if (q1.size() == 0) check("u1 unexpected rsp_valid", 1'b1, 1'b0);
        else begin
          exp_t e;
          e = q1.pop_front();
          check("u1 rdata", rdat1, e.data);
          check("u1 err", re1, e.err);
          check("u1 latency", cyc, e.due);
          check("u1 perr", rp1, e.perr);
        end
      end else begin
        check("u1 idle rdata", rdat1, 0);
      end
    end
  end

  // ---------------------------------------------------------------- stimulus tasks
  task automatic wr0(input logic [7:0] a, input logic [7:0] d, input logic be, input logic inj);
    @(negedge clk);
    check("u0 ready on write", rdy0, 1'b1);
    v0 = 1; w0 = 1; a0 = a; d0 = d; be0 = be; inj0 = inj;
    if (be) begin
      m0[a]   = d;
      bad0[a] = inj;
    end
  endtask

  task automatic rd0(input logic [7:0] a);
    exp_t e;
    @(negedge clk);
    check("u0 ready on read", rdy0, 1'b1);
    v0 = 1; w0 = 0; a0 = a; be0 = 0; inj0 = 0;
    e.data = 32'(m0[a]); e.err = 1'b0; e.perr = bad0[a]; e.due = cyc + L0;
    q0.push_back(e);
  endtask

  task automatic idle0();
    @(negedge clk);
    v0 = 0; w0 = 0;
  endtask

  task automatic wr1(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    check("u1 ready on write", rdy1, 1'b1);
    v1 = 1; w1 = 1; a1 = a; d1 = d; be1 = be;
    if (a < D1)
      for (int i = 0; i < 4; i++)
        if (be[i]) m1[a][8*i +: 8] = d[8*i +: 8];
  endtask

  task automatic rd1(input logic [7:0] a);
    exp_t e;
    @(negedge clk);
    check("u1 ready on read", rdy1, 1'b1);
    v1 = 1; w1 = 0; a1 = a; be1 = 0;
    e.err  = (a >= D1);
    e.data = e.err ? 32'h0 : m1[a];
    e.perr = 1'b0;
    e.due  = cyc + L1;
    q1.push_back(e);
  endtask

  task automatic idle1();
    @(negedge clk);
    v1 = 0; w1 = 0;
  endtask

  // Wait for both sweeps; report the cycle count after release at which each busy fell.
  task automatic wait_sweep(output int n0, output int n1, output int rdy_bad);
    int t;
    t = 0; n0 = 0; n1 = 0; rdy_bad = 0;
    while ((n0 == 0 || n1 == 0) && t < 400) begin
      @(negedge clk);
      t++;
      if (busy0 && rdy0) rdy_bad++;
      if (busy1 && rdy1) rdy_bad++;
      if (!busy0 && n0 == 0) n0 = t;
      if (!busy1 && n1 == 0) n1 = t;
    end
  endtask

  // ---------------------------------------------------------------- test sequence
  initial begin
    int n0, n1, rb, t;
    for (int i = 0; i < 256; i++) begin m0[i] = 8'h00; bad0[i] = 1'b0; end
    for (int i = 0; i < D1; i++) m1[i] = 32'h0;

    // reset state
    repeat (3) @(negedge clk);
    check("u0 busy in reset", busy0, 1'b1);
    check("u0 ready in reset", rdy0, 1'b0);
    check("u0 rsp_valid in reset", rv0, 1'b0);
    check("u1 busy in reset", busy1, 1'b1);
    check("u1 rsp_valid in reset", rv1, 1'b0);
    rst_n = 1;

    // init sweep length
    wait_sweep(n0, n1, rb);
    check("u0 sweep cycles", n0, 256);
    check("u1 sweep cycles", n1, D1);
    check("ready while busy", rb, 0);
    check("u0 ready after sweep", rdy0, 1'b1);
    check("u1 ready after sweep", rdy1, 1'b1);

    // u0: cleared contents, write/readback, read-after-write, be=0 no-op
    rd0(8'h7F);
    rd0(8'hFF);
    wr0(8'd5, 8'hA5, 1'b1, 1'b0);
    rd0(8'd5);
    wr0(8'd5, 8'hFF, 1'b0, 1'b0);
    rd0(8'd5);
    idle0();

    // u0: streaming back-to-back reads
    for (int i = 0; i < 8; i++) wr0(8'(i), 8'(8'h10 + i), 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) rd0(8'(i));
    idle0();

`ifdef MEM_SYNC_RW_PARITY_EN
    // u0: parity injection and clean rewrite
    wr0(8'd9, 8'h3C, 1'b1, 1'b1);
    rd0(8'd9);
    wr0(8'd9, 8'h3C, 1'b1, 1'b0);
    rd0(8'd9);
    idle0();
`endif

    // u1: byte enables, RD_LAT=4, range boundary
    wr1(8'd3, 32'h11223344, 4'hF);
    wr1(8'd3, 32'hAABBCCDD, 4'h5);
    rd1(8'd3);
    wr1(8'd5, 32'h000000A5, 4'h1);
    rd1(8'd5);
    wr1(8'd199, 32'hCAFEF00D, 4'hA);
    rd1(8'd199);
    wr1(8'd210, 32'hDEADBEEF, 4'hF);
    rd1(8'd210);
    rd1(8'd200);
    idle1();

    // drain outstanding responses
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("queues drained", q0.size() + q1.size(), 0);

    // reset with a read in flight on u1
    rd1(8'd3);
    @(posedge clk);
    #2;
    rst_n = 0;
    v1 = 0; w1 = 0;
    q1.delete();
    repeat (2) begin
      @(negedge clk);
      check("u1 rsp_valid during reset", rv1, 1'b0);
      check("u1 rdata during reset", rdat1, 0);
    end
    rst_n = 1;
    for (int i = 0; i < 256; i++) begin m0[i] = 8'h00; bad0[i] = 1'b0; end
    for (int i = 0; i < D1; i++) m1[i] = 32'h0;
    check("u1 busy on release", busy1, 1'b1);
    check("u1 ready on release", rdy1, 1'b0);
    check("u0 busy on release", busy0, 1'b1);

    wait_sweep(n0, n1, rb);
    check("u0 re-sweep cycles", n0, 256);
    check("u1 re-sweep cycles", n1, D1);

    // contents were cleared again
    rd1(8'd3);
    idle1();
    rd0(8'd5);
    idle0();

    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("final queues drained", q0.size() + q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
